// File: rtl/fc_feature_buffer_pkg.sv
// Shared constants and the FSM state encoding for the feature buffer that
// sits between the pooling stage and the fully connected layer.
// The FC and pooling top levels import this package so that all three blocks
// agree on the frame geometry.
package fc_feature_buffer_pkg;

  localparam int FB_NF    = 12;                       // filters (feature maps)
  localparam int FB_SPO   = 4;                        // pooled map side
  localparam int FB_DEPTH = FB_SPO * FB_SPO * FB_NF;  // 192 words per frame
  localparam int FB_AW    = $clog2(FB_DEPTH);         // storage address width

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fbuf_state_e;

endpackage

// File: rtl/fc_fbuf_mem.sv
// Distributed RAM that holds one feature frame.
// It has one synchronous write port and one asynchronous read port.
// Ports:
//   clk          write clock
//   we/waddr/wdata  write port, registered on the rising edge of clk
//   raddr/rdata     combinational read port
module fc_fbuf_mem #(
  parameter int M     = 32,
  parameter int DEPTH = 192,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [M-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [M-1:0]  rdata
);

  logic [M-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The caller masks reads whose address is at or beyond DEPTH.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fc_feature_buffer.sv
// Feature buffer placed directly upstream of the FC layer.
// - It captures a pooled frame arriving in filter-major order over a
//   valid/ready stream.
// - It stores the frame transposed, so that the FC layer reads it
//   position-major.
// - It holds the FC layer in reset until the frame is complete.
// - It serves Ii combinationally from the FC indices (FCi, Fi).
// - It raises done once the FC layer reports finish.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_data/in_ready        pooled word stream (ready only in FILL)
//   FCi, Fi                          FC position / filter index
//   Ii                               selected feature word (0 in FILL or out of range)
//   fc_finish                        FC completion flag (honoured in RUN)
//   fc_rst                           active-high reset into the FC layer
//   frame_start                      next-frame request (honoured in DONE)
//   done                             level, high while in DONE
module fc_feature_buffer
  import fc_feature_buffer_pkg::*;
#(
  parameter int M     = 32,
  parameter int Ma    = 16,
  parameter int N_f   = FB_NF,
  parameter int S_P_o = FB_SPO
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [M-1:0]  in_data,
  output logic          in_ready,
  input  logic [Ma-1:0] FCi,
  input  logic [Ma-1:0] Fi,
  input  logic          fc_finish,
  output logic [M-1:0]  Ii,
  output logic          fc_rst,
  input  logic          frame_start,
  output logic          done
);

  localparam int POS   = S_P_o * S_P_o;
  localparam int DEPTH = POS * N_f;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = (POS > 1) ? $clog2(POS) : 1;
  localparam int FW    = (N_f > 1) ? $clog2(N_f) : 1;
  localparam int RW    = Ma + AW;

  localparam logic [PW-1:0] WP_LAST = PW'(POS - 1);
  localparam logic [FW-1:0] WF_LAST = FW'(N_f - 1);
  localparam logic [AW-1:0] NF_AW   = AW'(N_f);

  fbuf_state_e   state, state_nxt;
  logic [PW-1:0] wp;
  logic [FW-1:0] wf;
  logic          accept, last_accept;
  logic [AW-1:0] waddr;
  logic [RW-1:0] rd_full;
  logic          rd_in_rng;
  logic [M-1:0]  rdata;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (wp == WP_LAST) && (wf == WF_LAST);

  // The transpose happens here: the stream arrives filter-major, and each
  // word is placed at its position-major slot.
  assign waddr = AW'(wp) * NF_AW + AW'(wf);

  // The read product is kept at full width so that a large FCi cannot alias
  // back into range before the bound check.
  assign rd_full   = RW'(FCi) * RW'(N_f) + RW'(Fi);
  assign rd_in_rng = rd_full < RW'(DEPTH);

  fc_fbuf_mem #(.M(M), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (rd_full[AW-1:0]),
    .rdata (rdata)
  );

  assign Ii = (state != FILL && rd_in_rng) ? rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (last_accept) state_nxt = RUN;
      RUN:     if (fc_finish)   state_nxt = DONE;
      DONE:    if (frame_start) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // The handshake and FC-control outputs are registered from the next state,
  // so that they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      fc_rst   <= 1'b1;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_nxt == FILL);
      fc_rst   <= (state_nxt == FILL);
      done     <= (state_nxt == DONE);
    end
  end

  // The position counter runs fastest. The filter counter steps on each
  // position wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      wf <= '0;
    end else if (accept) begin
      if (wp == WP_LAST) begin
        wp <= '0;
        wf <= (wf == WF_LAST) ? '0 : wf + 1'b1;
      end else begin
        wp <= wp + 1'b1;
      end
    end else if (state == DONE && frame_start) begin
      wp <= '0;
      wf <= '0;
    end
  end

endmodule

// File: tb/tb_fc_feature_buffer.sv
module tb_fc_feature_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [15:0] FCi, Fi;
  logic        fc_finish;
  logic [31:0] Ii;
  logic        fc_rst;
  logic        frame_start;
  logic        done;

  int passed = 0;
  int total  = 0;

  fc_feature_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .FCi         (FCi),
    .Fi          (Fi),
    .fc_finish   (fc_finish),
    .Ii          (Ii),
    .fc_rst      (fc_rst),
    .frame_start (frame_start),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept index k lands on wf=k/16, wp=k%16; data is base+k.
  task automatic feed(input int k0, input int n, input logic [31:0] base);
    for (int k = k0; k < k0 + n; k++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(k);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic rd(input int fc, input int f, input logic [31:0] exp, input string tag);
    FCi = 16'(fc);
    Fi  = 16'(f);
    #1;
    chk(tag, Ii, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; FCi = '0; Fi = '0;
    fc_finish = 1'b0; frame_start = 1'b0;

    // Reset
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_fc_rst",   32'(fc_rst),   1);
    chk("rst_done",     32'(done),     0);
    chk("rst_Ii",       Ii,            0);
    rst_n = 1'b1;

    // Back-to-back fill
    feed(0, 191, 32'h0);
    chk("fill191_fc_rst",   32'(fc_rst),   1);
    chk("fill191_in_ready", 32'(in_ready), 1);
    feed(191, 1, 32'h0);
    chk("fill192_fc_rst",   32'(fc_rst),   0);
    chk("fill192_in_ready", 32'(in_ready), 0);
    rd(5, 3, 32'd53,   "rd_5_3");
    rd(15, 11, 32'd191, "rd_15_11");
    rd(0, 1, 32'd16,   "rd_0_1");
    rd(0, 191, 32'd191, "rd_0_191");

    // Out of range
    rd(16, 0, 32'd0, "oor_16_0");
    rd(15, 12, 32'd0, "oor_15_12");
    rd(65535, 65535, 32'd0, "oor_max");

    // Writes in RUN are ignored
    in_valid = 1'b1; in_data = 32'hDEAD;
    step(); step(); step();
    in_valid = 1'b0;
    chk("run_in_ready", 32'(in_ready), 0);
    rd(5, 3, 32'd53, "run_nowrite_5_3");
    rd(0, 0, 32'd0,  "run_nowrite_0_0");

    // frame_start in RUN is ignored
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("run_fs_done",   32'(done),   0);
    chk("run_fs_fc_rst", 32'(fc_rst), 0);

    // Finish
    fc_finish = 1'b1; step(); fc_finish = 1'b0;
    chk("fin_done",   32'(done),   1);
    chk("fin_fc_rst", 32'(fc_rst), 0);
    rd(5, 3, 32'd53, "done_serve_5_3");
    step();
    chk("done_hold", 32'(done), 1);

    // Restart
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("rs_in_ready", 32'(in_ready), 1);
    chk("rs_fc_rst",   32'(fc_rst),   1);
    chk("rs_done",     32'(done),     0);
    rd(5, 3, 32'd0, "rs_Ii_zero");

    // Throttled fill: valid on even cycles, 192nd accept at cycle 382
    for (int i = 0; i <= 382; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 32'h1000 + 32'(i / 2);
      step();
      if (i == 381) chk("thr381_fc_rst", 32'(fc_rst), 1);
    end
    in_valid = 1'b0;
    chk("thr_fc_rst",   32'(fc_rst),   0);
    chk("thr_in_ready", 32'(in_ready), 0);
    rd(5, 3, 32'h1000 + 32'd53,   "thr_5_3");
    rd(15, 11, 32'h1000 + 32'd191, "thr_15_11");

    fc_finish = 1'b1; step(); fc_finish = 1'b0;
    chk("thr_fin_done", 32'(done), 1);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("thr_rs_fc_rst", 32'(fc_rst), 1);

    // Reset mid-fill
    feed(0, 50, 32'h2000);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_fc_rst",   32'(fc_rst),   1);
    feed(0, 191, 32'h3000);
    chk("mid191_fc_rst", 32'(fc_rst), 1);
    feed(191, 1, 32'h3000);
    chk("mid192_fc_rst", 32'(fc_rst), 0);
    rd(5, 3, 32'h3000 + 32'd53, "mid_5_3");
    rd(3, 1, 32'h3000 + 32'd19, "mid_3_1");
    rd(15, 11, 32'h3000 + 32'd191, "mid_15_11");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
